// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: PS/2 host-to-keyboard command sequencer; optional phase timeout enabled by PS2_CMD_TIMEOUT_EN
module ps2_cmd_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       psClk_in,
    input  logic       psData_in,
    output logic       psClk_oe,
    output logic       psData_oe,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       has_arg,
    input  logic [7:0] arg_byte,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_consume,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, START = 3'd2, TX_BITS = 3'd3,
                           TX_ACK = 3'd4, WAIT_RESP = 3'd5, DONE = 3'd6, ERR = 3'd7;
    logic [2:0]  state;
    logic        clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic        fall, resp, do_retry, can_retry, tmo_exp;
    logic [31:0] cnt;
    logic [7:0]  cur, arg, retry;
    logic        has_arg_q, arg_sent, data_oe;
    logic [3:0]  k;

    assign psClk_oe  = state == INHIBIT;
    assign psData_oe = data_oe && (state == START || state == TX_BITS);
    assign cmd_ready = state == IDLE;
    assign busy      = !(state == IDLE || state == DONE || state == ERR);
    assign done      = state == DONE;
    assign err       = state == ERR;

    // synchronise the pads and keep the previous clock sample for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) {clk_s1, clk_s2, clk_prev, dat_s1, dat_s2} <= 5'b11111;
        else {clk_s1, clk_s2, clk_prev, dat_s1, dat_s2} <= {psClk_in, clk_s1, clk_s2, psData_in, dat_s1};
    end

    // decode falling edges, device responses and retry requests
    always_comb begin
        fall      = clk_prev & ~clk_s2;
        resp      = state == WAIT_RESP && rx_valid && (rx_byte == 8'hFA || rx_byte == 8'hFE);
        do_retry  = (state == TX_ACK && fall && dat_s2) || (state == WAIT_RESP && rx_valid && rx_byte == 8'hFE);
        can_retry = retry < 8'(MAX_RETRY);
    end

`ifdef PS2_CMD_TIMEOUT_EN
    logic [31:0] tmo;
    // phase timer: cleared while inhibiting (so it starts fresh in START) and on every device clock edge
    always_ff @(posedge Clk) begin
        if (Reset || fall || state == INHIBIT) tmo <= '0;
        else tmo <= tmo + 32'd1;
    end
    assign tmo_exp = (state == TX_BITS || state == TX_ACK || state == WAIT_RESP) &&
                     tmo == 32'(TIMEOUT_CYCLES - 1) && !fall && !resp;
`else
    assign tmo_exp = TIMEOUT_CYCLES < 0;
`endif

    // response bytes are consumed here so the scan-code path can drop them
    always_ff @(posedge Clk) begin
        if (Reset) rx_consume <= 1'b0;
        else rx_consume <= resp;
    end

    // command sequencer; retries and timeouts override the per-state next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cur       <= '0;
            arg       <= '0;
            retry     <= '0;
            has_arg_q <= 1'b0;
            arg_sent  <= 1'b0;
            data_oe   <= 1'b0;
            k         <= '0;
            err_code  <= 2'b00;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cur       <= cmd_byte;
                    arg       <= arg_byte;
                    has_arg_q <= has_arg;
                    arg_sent  <= 1'b0;
                    retry     <= '0;
                    err_code  <= 2'b00;
                    cnt       <= '0;
                    state     <= INHIBIT;
                end
                INHIBIT: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
                        data_oe <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    k     <= '0;
                    state <= TX_BITS;
                end
                TX_BITS: if (fall) begin
                    data_oe <= k < 4'd8 ? ~cur[k[2:0]] : k == 4'd8 ? ^cur : 1'b0;
                    k       <= k + 4'd1;
                    if (k == 4'd9) state <= TX_ACK;
                end
                TX_ACK: if (fall && !dat_s2) state <= WAIT_RESP;
                WAIT_RESP: if (rx_valid && rx_byte == 8'hFA) begin
                    if (has_arg_q && !arg_sent) begin
                        cur      <= arg;
                        arg_sent <= 1'b1;
                        retry    <= '0;
                        cnt      <= '0;
                        state    <= INHIBIT;
                    end else state <= DONE;
                end
                default: state <= IDLE;
            endcase
            if (do_retry) begin
                if (can_retry) begin
                    retry <= retry + 8'd1;
                    cnt   <= '0;
                    state <= INHIBIT;
                end else begin
                    err_code <= 2'b01;
                    state    <= ERR;
                end
            end
            if (tmo_exp) begin
                err_code <= 2'b10;
                state    <= ERR;
            end
        end
    end
endmodule
